// File: rtl/alu_seq_pkg.sv
// Shared defaults, FSM state type and response record for the ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_SEL_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] data;
    logic                      carry;
    logic [DEFAULT_SEL_W-1:0]  sel;
  } rsp_t;

endpackage

// File: rtl/ALU_16bit.sv
// Combinational 16-bit ALU driven by the sequencer; CarryOut is the carry of A+B.
module ALU_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  ALU_Sel,
  output logic [15:0] ALU_Out,
  output logic        CarryOut
);

  logic [16:0] w_sum;

  assign w_sum    = {1'b0, A} + {1'b0, B};
  assign CarryOut = w_sum[16];

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      4'h0: ALU_Out = w_sum[15:0];
      4'h1: ALU_Out = A - B;
      4'h2: ALU_Out = A * B;
      4'h3: ALU_Out = (B == 16'd0) ? 16'hFFFF : A / B;
      4'h4: ALU_Out = A << 1;
      4'h5: ALU_Out = A >> 1;
      4'h6: ALU_Out = {A[14:0], A[15]};
      4'h7: ALU_Out = {A[0], A[15:1]};
      4'h8: ALU_Out = A & B;
      4'h9: ALU_Out = A | B;
      4'hA: ALU_Out = A ^ B;
      4'hB: ALU_Out = ~(A | B);
      4'hC: ALU_Out = ~(A & B);
      4'hD: ALU_Out = ~(A ^ B);
      4'hE: ALU_Out = (A > B) ? 16'd1 : 16'd0;
      4'hF: ALU_Out = (A == B) ? 16'd1 : 16'd0;
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO; head is zeroed whenever the FIFO is empty.
module alu_rsp_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = $bits(rsp_t),
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences commands onto an external ALU: holds operands SETTLE_CYC cycles, then
// captures result, carry and select into a response FIFO.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned SEL_W      = DEFAULT_SEL_W,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              busy,
  output logic [7:0]        cmd_count
);

  localparam int unsigned RSP_W = DATA_W + 1 + SEL_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e            r_state;
  logic [3:0]        r_settle;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [SEL_W-1:0]  r_sel;
  logic [7:0]        r_count;

  logic              w_accept;
  logic              w_capture;
  logic [CNT_W-1:0]  w_occ;
  logic [RSP_W-1:0]  w_push_data;
  logic [RSP_W-1:0]  w_head;

  assign cmd_ready   = (r_state == IDLE) && (w_occ < CNT_W'(FIFO_DEPTH));
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_capture   = (r_state == DRIVE) && (r_settle == 4'd0);
  assign w_push_data = {alu_out, alu_carry, r_sel};

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign busy      = (r_state == DRIVE);
  assign cmd_count = r_count;

  assign rsp_data  = w_head[RSP_W-1 -: DATA_W];
  assign rsp_carry = w_head[SEL_W];
  assign rsp_sel   = w_head[SEL_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_settle <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= cmd_a;
            r_b      <= cmd_b;
            r_sel    <= cmd_sel;
            r_settle <= 4'(SETTLE_CYC - 1);
            r_state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_settle == 4'd0) begin
            r_count <= r_count + 8'd1;
            r_state <= IDLE;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Admission checks occupancy, so the capture push can never overflow.
  alu_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_capture),
    .i_data  (w_push_data),
    .i_pop   (rsp_ready),
    .o_valid (rsp_valid),
    .o_data  (w_head),
    .o_count (w_occ)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl driving an ALU_16bit; expected results come from
// an arithmetic reference of the ALU operation table.
module tb_alu_seq_ctrl;

  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [3:0]  cmd_sel = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic [3:0]  rsp_sel;
  logic        busy;
  logic [7:0]  cmd_count;

  typedef struct {
    logic [15:0] data;
    logic        carry;
    logic [3:0]  sel;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   exp_count = 0;
  bit   rand_ready = 1'b0;

  alu_seq_ctrl #(
    .DATA_W     (16),
    .SEL_W      (4),
    .SETTLE_CYC (SETTLE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_sel   (rsp_sel),
    .busy      (busy),
    .cmd_count (cmd_count)
  );

  ALU_16bit u_alu (
    .A        (alu_a),
    .B        (alu_b),
    .ALU_Sel  (alu_sel),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {carry, result}.
  function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r;
    logic [15:0] lr;
    lr = '0;
    r  = 0;
    case (s)
      4'h0: r = ua + ub;
      4'h1: r = ua - ub + 65536;
      4'h2: r = ua * ub;
      4'h3: r = (ub == 0) ? 65535 : ua / ub;
      4'h4: r = ua * 2;
      4'h5: r = ua / 2;
      4'h6: r = ua * 2 + ua / 32768;
      4'h7: r = ua / 2 + (ua % 2) * 32768;
      4'h8: begin lr = a & b;    r = longint'(lr); end
      4'h9: begin lr = a | b;    r = longint'(lr); end
      4'hA: begin lr = a ^ b;    r = longint'(lr); end
      4'hB: begin lr = ~(a | b); r = longint'(lr); end
      4'hC: begin lr = ~(a & b); r = longint'(lr); end
      4'hD: begin lr = ~(a ^ b); r = longint'(lr); end
      4'hE: r = (ua > ub) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    return {((ua + ub) > 65535), 16'(r % 65536)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got data 0x%0h sel 0x%0h, want no response",
                 rsp_data, rsp_sel);
      end else begin
        e = sb.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_carry", rsp_carry, e.carry);
        check("rsp_sel", rsp_sel, e.sel);
        check("rsp_not_early", cyc >= e.acc + SETTLE, 1);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    int waited = 0;
    logic [16:0] r;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: cmd_ready low for %0d cycles, want accept", waited);
      cmd_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    r = ref_alu(a, b, s);
    sb.push_back('{data: r[15:0], carry: r[16], sel: s, acc: last_acc});
    exp_count = (exp_count + 1) % 256;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    rand_ready = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_rsp_valid", rsp_valid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc_t[12];
    int rel_cyc;
    int pop_edge;
    int bad;
    logic [15:0] ra, rb;

    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_sel", rsp_sel, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;

    // Single command latency and first-edge accept after reset.
    send(16'h000A, 16'h0002, 4'h1);
    check("first_accept_edge", last_acc, rel_cyc + 1);
    @(negedge clk);
    check("drive_busy", busy, 1);
    check("drive_alu_a", alu_a, 16'h000A);
    check("drive_alu_sel", alu_sel, 4'h1);
    check("k0_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("k1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("k2_rsp_valid", rsp_valid, 1);
    check("k2_busy", busy, 0);
    check("k2_cmd_count", cmd_count, 1);
    check("hold_alu_b", alu_b, 16'h0002);
    drain();

    // Back-to-back select sweep.
    for (int s = 1; s <= 12; s++) begin
      send(16'h00F6, 16'h00FF, 4'(s));
      acc_t[s-1] = last_acc;
    end
    for (int i = 1; i < 12; i++) check("sweep_spacing", acc_t[i] - acc_t[i-1], SETTLE + 1);
    drain();
    check("sweep_cmd_count", cmd_count, exp_count);

    // Backpressure: fill the FIFO, fifth command must wait for a pop.
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    repeat (3) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 0);
    check("full_rsp_valid", rsp_valid, 1);
    ra = 16'hFFFF; rb = 16'h0001;
    cmd_a = ra; cmd_b = rb; cmd_sel = 4'h0; cmd_valid = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ready || busy) bad++;
    end
    check("full_no_accept", bad, 0);
    check("full_cmd_count", cmd_count, exp_count);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    pop_edge = cyc + 1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(ra, rb, 4'h0);
    check("fifth_after_pop", last_acc, pop_edge + 1);

    // Pop coincident with the capture push keeps occupancy steady.
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("pushpop_cmd_ready", cmd_ready, 1);
    check("pushpop_rsp_valid", rsp_valid, 1);
    send(16'h8000, 16'h8000, 4'h0);
    repeat (3) @(negedge clk);
    check("refill_cmd_ready", cmd_ready, 0);
    drain();

    // Reset in DRIVE discards the in-flight command.
    send(16'h1234, 16'h4321, 4'h2);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_sel", alu_sel, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_count", cmd_count, 0);
    sb.delete();
    exp_count = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
    send(16'h0003, 16'h0000, 4'h3);
    check("post_rst_accept_edge", last_acc, rel_cyc + 1);
    drain();
    check("post_rst_cmd_count", cmd_count, 1);

    // Random traffic up to the cmd_count wrap.
    rand_ready = 1'b1;
    for (int i = 0; i < 254; i++) begin
      ra = (i % 9 == 0) ? 16'hFFFF : 16'($urandom);
      rb = (i % 7 == 0) ? 16'h0000 : 16'($urandom);
      send(ra, rb, 4'($urandom_range(0, 15)));
    end
    drain();
    check("count_255", cmd_count, 8'd255);
    send(16'h7FFF, 16'h8001, 4'h0);
    drain();
    check("count_wrap", cmd_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
